p2s_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one parallel_to_serial_converter between NUM_REQ parallel word sources.
- Sits directly upstream of the converter and drives its par_data/par_valid, honouring par_ready.
- Accepts one word at a time from the winning requester, holds it in a register until the converter takes it, then rotates priority.
- Reports which requester owns the word currently offered.

---
 rtl/p2s_pkg.sv | 11 +
 rtl/p2s_rr_pick.sv | 34 +++
 rtl/p2s_rr_scheduler.sv | 147 ++++++++++++++
 tb/tb_p2s_rr_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared types and constants for the p2s round-robin scheduler
package p2s_pkg;

  localparam int P2S_N = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } p2s_sched_state_e;

endpackage

// File: rtl/p2s_rr_pick.sv
// rtl/p2s_rr_pick.sv - combinational round-robin picker
// Searches last_grant+1, last_grant+2, ... modulo NUM_REQ; first valid index wins.
module p2s_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  always_comb begin
    logic [ID_W:0] cand;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // One spare bit so the wrap works by compare for non-power-of-2 NUM_REQ.
      cand = {1'b0, last_grant} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(NUM_REQ)) begin
        cand = cand - (ID_W + 1)'(NUM_REQ);
      end
      if (!any_valid && valid[cand[ID_W-1:0]]) begin
        any_valid                = 1'b1;
        grant[cand[ID_W-1:0]]    = 1'b1;
        grant_idx                = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/p2s_rr_scheduler.sv
// rtl/p2s_rr_scheduler.sv - round-robin feeder for one parallel_to_serial_converter
// Optional macro P2S_SCHED_BURST_EN lets a granted requester stream up to BURST_LEN words.
module p2s_rr_scheduler
  import p2s_pkg::*;
#(
  parameter int N         = P2S_N,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ*N-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [N-1:0]         par_data,
  output logic                 par_valid,
  input  logic                 par_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 1) begin : g_bad_params
    $error("p2s_rr_scheduler: NUM_REQ must be 2..16 and BURST_LEN >= 1");
  end

  p2s_sched_state_e state, state_d;
  logic [ID_W-1:0]    last_grant;
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               load_new;
  logic               release_word;

  p2s_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .any_valid  (pick_any)
  );

  assign busy = (state == HOLD);

`ifdef P2S_SCHED_BURST_EN
  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  logic [BCNT_W-1:0] burst_cnt;
  logic              burst_take;

  always_comb begin
    state_d      = state;
    req_ready    = '0;
    load_new     = 1'b0;
    release_word = 1'b0;
    burst_take   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          load_new  = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (par_ready) begin
          // Same requester may refill the register in the handshake cycle.
          if (req_valid[grant_id] && (burst_cnt < BCNT_W'(BURST_LEN - 1))) begin
            req_ready[grant_id] = 1'b1;
            burst_take          = 1'b1;
          end else begin
            release_word = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      burst_cnt <= '0;
    end else if (burst_take) begin
      burst_cnt <= burst_cnt + 1'b1;
    end else if (release_word) begin
      burst_cnt <= '0;
    end
  end
`else
  logic burst_take;
  assign burst_take = 1'b0;

  always_comb begin
    state_d      = state;
    req_ready    = '0;
    load_new     = 1'b0;
    release_word = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          load_new  = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (par_ready) begin
          release_word = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_data   <= '0;
      par_valid  <= 1'b0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      if (load_new) begin
        par_data  <= req_data[int'(pick_idx)*N +: N];
        grant_id  <= pick_idx;
        par_valid <= 1'b1;
      end else if (burst_take) begin
        par_data <= req_data[int'(grant_id)*N +: N];
      end else if (release_word) begin
        par_valid  <= 1'b0;
        last_grant <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// tb/tb_p2s_rr_scheduler.sv - table-driven bench for p2s_rr_scheduler
module tb_p2s_rr_scheduler;

  localparam int N       = 8;
  localparam int NUM_REQ = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NUM_REQ*N-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [N-1:0]         par_data;
  logic                 par_valid;
  logic                 par_ready = 1'b0;
  logic [1:0]           grant_id;
  logic                 busy;

  p2s_rr_scheduler #(.N(N), .NUM_REQ(NUM_REQ), .BURST_LEN(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rs;
    logic [3:0]  v;
    logic [31:0] d;
    logic        pr;
    logic [3:0]  e_rr;
    logic        e_pv;
    logic        chk_pd;
    logic [7:0]  e_pd;
    logic [1:0]  e_gid;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] D  = 32'h281E140A;
  localparam logic [31:0] D2 = 32'h283E140A;

  function automatic logic [31:0] bd(input logic [7:0] w);
    return {8'd0, 8'd99, w, 8'd0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic [3:0] v, input logic [31:0] d, input logic pr,
                     input logic [3:0] rr, input logic pv, input logic cp, input logic [7:0] pd,
                     input logic [1:0] g, input logic b);
    vecs.push_back({rs, v, d, pr, rr, pv, cp, pd, g, b});
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    par_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    // Test 1: idle after reset
    add(1, 4'b0000, D, 1, 4'b0000, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, D, 1, 4'b0000, 0, 1, 0, 0, 0);
    // Test 2: single requester 2
    add(0, 4'b0100, D2, 1, 4'b0100, 1, 1, 62, 2, 1);
    add(0, 4'b0000, D2, 1, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b0000, D2, 1, 4'b0000, 0, 0, 0, 0, 0);
`ifndef P2S_SCHED_BURST_EN
    // Test 3: all valid, grants rotate 0,1,2,3,0
    add(1, 4'b1111, D, 1, 4'b0001, 1, 1, 10, 0, 1);
    add(0, 4'b1111, D, 1, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b1111, D, 1, 4'b0010, 1, 1, 20, 1, 1);
    add(0, 4'b1111, D, 1, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b1111, D, 1, 4'b0100, 1, 1, 30, 2, 1);
    add(0, 4'b1111, D, 1, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b1111, D, 1, 4'b1000, 1, 1, 40, 3, 1);
    add(0, 4'b1111, D, 1, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b1111, D, 1, 4'b0001, 1, 1, 10, 0, 1);
    add(0, 4'b1111, D, 1, 4'b0000, 0, 0, 0, 0, 0);
    // Test 4: backpressure then skip to requester 3
    add(1, 4'b1001, D, 0, 4'b0001, 1, 1, 10, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 4'b1001, D, 0, 4'b0000, 1, 1, 10, 0, 1);
    add(0, 4'b1001, D, 1, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b1001, D, 1, 4'b1000, 1, 1, 40, 3, 1);
    add(0, 4'b1001, D, 1, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b1001, D, 1, 4'b0001, 1, 1, 10, 0, 1);
`else
    // Test 6: burst of four from requester 1, then requester 2, then requester 1 again
    add(1, 4'b0110, bd(1), 1, 4'b0010, 1, 1, 1, 1, 1);
    add(0, 4'b0110, bd(2), 1, 4'b0010, 1, 1, 2, 1, 1);
    add(0, 4'b0110, bd(3), 1, 4'b0010, 1, 1, 3, 1, 1);
    add(0, 4'b0110, bd(4), 1, 4'b0010, 1, 1, 4, 1, 1);
    add(0, 4'b0110, bd(5), 1, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b0110, bd(5), 1, 4'b0100, 1, 1, 99, 2, 1);
    add(0, 4'b0010, bd(5), 1, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b0010, bd(5), 1, 4'b0010, 1, 1, 5, 1, 1);
    add(0, 4'b0010, bd(6), 1, 4'b0010, 1, 1, 6, 1, 1);
    add(0, 4'b0000, bd(6), 1, 4'b0000, 0, 0, 0, 0, 0);
`endif

    do_reset();
    chk("reset_par_valid", 32'(par_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_grant_id", 32'(grant_id), 0);
    chk("reset_req_ready", 32'(req_ready), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rs) do_reset();
      req_valid = vecs[i].v;
      req_data  = vecs[i].d;
      par_ready = vecs[i].pr;
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_par_valid", i), 32'(par_valid), 32'(vecs[i].e_pv));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].chk_pd) begin
        chk($sformatf("v%0d_par_data", i), 32'(par_data), 32'(vecs[i].e_pd));
        chk($sformatf("v%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].e_gid));
      end
    end

    // Test 5: asynchronous reset while holding a word
    do_reset();
    req_data  = 32'h00000034;
    req_valid = 4'b0001;
    par_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst5_hold_valid", 32'(par_valid), 1);
    chk("rst5_hold_data", 32'(par_data), 52);
    req_valid = 4'b0000;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst5_async_valid", 32'(par_valid), 0);
    chk("rst5_async_busy", 32'(busy), 0);
    chk("rst5_async_data", 32'(par_data), 0);
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    req_data  = D;
    req_valid = 4'b1111;
    par_ready = 1'b1;
    #1;
    chk("rst5_after_req_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("rst5_after_grant", 32'(grant_id), 0);
    chk("rst5_after_data", 32'(par_data), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
